// File: rtl/munoc_axi_slave_rw_scheduler.sv
// Serialises NI write/read traffic onto a slave that holds one outstanding transaction at a time.
// Define MUNOC_RW_SCHED_TIMEOUT_EN to add the watchdog that aborts a stuck transaction with SLVERR.
`ifndef DEFAULT_BW_AXI_TID
`define DEFAULT_BW_AXI_TID 4
`endif

module munoc_axi_slave_rw_scheduler #(
  parameter int BW_PLATFORM_ADDR = 32,
  parameter int BW_NODE_DATA     = 32,
  parameter int BW_AXI_SLAVE_TID = `DEFAULT_BW_AXI_TID,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clk_slave,
  input  logic                          rst_slave,
  input  logic                          comm_disable,
  input  logic [BW_AXI_SLAVE_TID-1:0]   up_awid,
  input  logic [BW_PLATFORM_ADDR-1:0]   up_awaddr,
  input  logic [7:0]                    up_awlen,
  input  logic [2:0]                    up_awsize,
  input  logic [1:0]                    up_awburst,
  input  logic                          up_awvalid,
  output logic                          up_awready,
  input  logic [BW_AXI_SLAVE_TID-1:0]   up_wid,
  input  logic [BW_NODE_DATA-1:0]       up_wdata,
  input  logic [BW_NODE_DATA/8-1:0]     up_wstrb,
  input  logic                          up_wlast,
  input  logic                          up_wvalid,
  output logic                          up_wready,
  output logic [BW_AXI_SLAVE_TID-1:0]   up_bid,
  output logic [1:0]                    up_bresp,
  output logic                          up_bvalid,
  input  logic                          up_bready,
  input  logic [BW_AXI_SLAVE_TID-1:0]   up_arid,
  input  logic [BW_PLATFORM_ADDR-1:0]   up_araddr,
  input  logic [7:0]                    up_arlen,
  input  logic [2:0]                    up_arsize,
  input  logic [1:0]                    up_arburst,
  input  logic                          up_arvalid,
  output logic                          up_arready,
  output logic [BW_AXI_SLAVE_TID-1:0]   up_rid,
  output logic [BW_NODE_DATA-1:0]       up_rdata,
  output logic [1:0]                    up_rresp,
  output logic                          up_rlast,
  output logic                          up_rvalid,
  input  logic                          up_rready,
  output logic [BW_AXI_SLAVE_TID-1:0]   dn_awid,
  output logic [BW_PLATFORM_ADDR-1:0]   dn_awaddr,
  output logic [7:0]                    dn_awlen,
  output logic [2:0]                    dn_awsize,
  output logic [1:0]                    dn_awburst,
  output logic                          dn_awvalid,
  input  logic                          dn_awready,
  output logic [BW_AXI_SLAVE_TID-1:0]   dn_wid,
  output logic [BW_NODE_DATA-1:0]       dn_wdata,
  output logic [BW_NODE_DATA/8-1:0]     dn_wstrb,
  output logic                          dn_wlast,
  output logic                          dn_wvalid,
  input  logic                          dn_wready,
  input  logic [BW_AXI_SLAVE_TID-1:0]   dn_bid,
  input  logic [1:0]                    dn_bresp,
  input  logic                          dn_bvalid,
  output logic                          dn_bready,
  output logic [BW_AXI_SLAVE_TID-1:0]   dn_arid,
  output logic [BW_PLATFORM_ADDR-1:0]   dn_araddr,
  output logic [7:0]                    dn_arlen,
  output logic [2:0]                    dn_arsize,
  output logic [1:0]                    dn_arburst,
  output logic                          dn_arvalid,
  input  logic                          dn_arready,
  input  logic [BW_AXI_SLAVE_TID-1:0]   dn_rid,
  input  logic [BW_NODE_DATA-1:0]       dn_rdata,
  input  logic [1:0]                    dn_rresp,
  input  logic                          dn_rlast,
  input  logic                          dn_rvalid,
  output logic                          dn_rready,
  output logic                          busy,
  output logic                          timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, ERR_B, ERR_R
  } state_t;

  state_t state_q, state_d;
  logic   last_wr_q;
  logic   in_wr_addr, in_wr_data, in_wr_resp, in_rd_addr, in_rd_data;
  logic   aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
  logic   wd_expire;

  assign in_wr_addr = (state_q == WR_ADDR);
  assign in_wr_data = (state_q == WR_DATA);
  assign in_wr_resp = (state_q == WR_RESP);
  assign in_rd_addr = (state_q == RD_ADDR);
  assign in_rd_data = (state_q == RD_DATA);
  assign busy       = (state_q != IDLE);

  assign dn_awid    = up_awid;
  assign dn_awaddr  = up_awaddr;
  assign dn_awlen   = up_awlen;
  assign dn_awsize  = up_awsize;
  assign dn_awburst = up_awburst;
  assign dn_awvalid = up_awvalid & in_wr_addr;
  assign up_awready = dn_awready & in_wr_addr;

  assign dn_wid     = up_wid;
  assign dn_wdata   = up_wdata;
  assign dn_wstrb   = up_wstrb;
  assign dn_wlast   = up_wlast;
  assign dn_wvalid  = up_wvalid & in_wr_data;
  assign up_wready  = dn_wready & in_wr_data;
  assign dn_bready  = up_bready & in_wr_resp;

  assign dn_arid    = up_arid;
  assign dn_araddr  = up_araddr;
  assign dn_arlen   = up_arlen;
  assign dn_arsize  = up_arsize;
  assign dn_arburst = up_arburst;
  assign dn_arvalid = up_arvalid & in_rd_addr;
  assign up_arready = dn_arready & in_rd_addr;
  assign up_rdata   = dn_rdata;
  assign dn_rready  = up_rready & in_rd_data;

  assign aw_hs     = dn_awvalid & dn_awready;
  assign w_last_hs = dn_wvalid & dn_wready & up_wlast;
  assign b_hs      = dn_bvalid & dn_bready;
  assign ar_hs     = dn_arvalid & dn_arready;
  assign r_last_hs = dn_rvalid & dn_rready & dn_rlast;

  // On a tie the direction that was not granted last time wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!comm_disable) begin
          if (up_awvalid && (!up_arvalid || !last_wr_q)) state_d = WR_ADDR;
          else if (up_arvalid)                           state_d = RD_ADDR;
        end
      end
      WR_ADDR: if (aw_hs)     state_d = WR_DATA;
      WR_DATA: if (w_last_hs) state_d = WR_RESP;
      WR_RESP: if (b_hs)      state_d = IDLE;
      RD_ADDR: if (ar_hs)     state_d = RD_DATA;
      RD_DATA: if (r_last_hs) state_d = IDLE;
      ERR_B:   if (up_bready) state_d = IDLE;
      ERR_R:   if (up_rready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
    if (wd_expire) begin
      if (in_wr_resp)      state_d = ERR_B;
      else if (in_rd_data) state_d = ERR_R;
      else                 state_d = IDLE;
    end
  end

  always_ff @(posedge clk_slave) begin
    if (rst_slave) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == WR_ADDR)      last_wr_q <= 1'b1;
      else if (state_q == IDLE && state_d == RD_ADDR) last_wr_q <= 1'b0;
    end
  end

`ifdef MUNOC_RW_SCHED_TIMEOUT_EN
  logic [15:0]                 wd_cnt_q;
  logic                        timeout_q, wd_active, phase_hs;
  logic [BW_AXI_SLAVE_TID-1:0] wr_id_q, rd_id_q;

  assign wd_active = in_wr_addr | in_wr_data | in_wr_resp | in_rd_addr | in_rd_data;
  assign phase_hs  = aw_hs | (dn_wvalid & dn_wready) | b_hs | ar_hs | (dn_rvalid & dn_rready);
  assign wd_expire = wd_active && (wd_cnt_q == 16'(TIMEOUT_CYCLES));
  assign timeout   = timeout_q;

  // Any progress in the current phase restarts the watchdog; the flag stays set until reset.
  always_ff @(posedge clk_slave) begin
    if (rst_slave) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!wd_active || phase_hs || wd_expire) wd_cnt_q <= '0;
      else                                     wd_cnt_q <= wd_cnt_q + 16'd1;
      if (wd_expire) timeout_q <= 1'b1;
    end
    if (aw_hs) wr_id_q <= up_awid;
    if (ar_hs) rd_id_q <= up_arid;
  end

  assign up_bvalid = (state_q == ERR_B) | (dn_bvalid & in_wr_resp);
  assign up_bid    = (state_q == ERR_B) ? wr_id_q : dn_bid;
  assign up_bresp  = (state_q == ERR_B) ? 2'b10 : dn_bresp;
  assign up_rvalid = (state_q == ERR_R) | (dn_rvalid & in_rd_data);
  assign up_rid    = (state_q == ERR_R) ? rd_id_q : dn_rid;
  assign up_rresp  = (state_q == ERR_R) ? 2'b10 : dn_rresp;
  assign up_rlast  = (state_q == ERR_R) | dn_rlast;
`else
  logic unused_cfg;

  assign unused_cfg = |TIMEOUT_CYCLES;
  assign wd_expire  = 1'b0;
  assign timeout    = 1'b0;
  assign up_bvalid  = dn_bvalid & in_wr_resp;
  assign up_bid     = dn_bid;
  assign up_bresp   = dn_bresp;
  assign up_rvalid  = dn_rvalid & in_rd_data;
  assign up_rid     = dn_rid;
  assign up_rresp   = dn_rresp;
  assign up_rlast   = dn_rlast;
`endif

endmodule

// File: tb/tb_munoc_axi_slave_rw_scheduler.sv
// Randomised bench acting as both NI and slave; a transaction-level model predicts grant order and timing.
module tb_munoc_axi_slave_rw_scheduler;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int BUDGET = 400;

  logic          clk_slave = 1'b0;
  logic          rst_slave, comm_disable;
  logic [IW-1:0] up_awid, up_wid, up_bid, up_arid, up_rid;
  logic [AW-1:0] up_awaddr, up_araddr;
  logic [7:0]    up_awlen, up_arlen;
  logic [2:0]    up_awsize, up_arsize;
  logic [1:0]    up_awburst, up_arburst, up_bresp, up_rresp;
  logic [DW-1:0] up_wdata, up_rdata;
  logic [SW-1:0] up_wstrb;
  logic          up_awvalid, up_awready, up_wlast, up_wvalid, up_wready, up_bvalid, up_bready;
  logic          up_arvalid, up_arready, up_rlast, up_rvalid, up_rready;
  logic [IW-1:0] dn_awid, dn_wid, dn_bid, dn_arid, dn_rid;
  logic [AW-1:0] dn_awaddr, dn_araddr;
  logic [7:0]    dn_awlen, dn_arlen;
  logic [2:0]    dn_awsize, dn_arsize;
  logic [1:0]    dn_awburst, dn_arburst, dn_bresp, dn_rresp;
  logic [DW-1:0] dn_wdata, dn_rdata;
  logic [SW-1:0] dn_wstrb;
  logic          dn_awvalid, dn_awready, dn_wlast, dn_wvalid, dn_wready, dn_bvalid, dn_bready;
  logic          dn_arvalid, dn_arready, dn_rlast, dn_rvalid, dn_rready;
  logic          busy, timeout;

  int num_checks = 0;
  int num_pass   = 0;
  bit model_last_wr;

  always #5 clk_slave = ~clk_slave;

  munoc_axi_slave_rw_scheduler #(
    .BW_PLATFORM_ADDR(AW), .BW_NODE_DATA(DW), .BW_AXI_SLAVE_TID(IW), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk_slave(clk_slave), .rst_slave(rst_slave), .comm_disable(comm_disable),
    .up_awid(up_awid), .up_awaddr(up_awaddr), .up_awlen(up_awlen), .up_awsize(up_awsize),
    .up_awburst(up_awburst), .up_awvalid(up_awvalid), .up_awready(up_awready),
    .up_wid(up_wid), .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wlast(up_wlast),
    .up_wvalid(up_wvalid), .up_wready(up_wready),
    .up_bid(up_bid), .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
    .up_arid(up_arid), .up_araddr(up_araddr), .up_arlen(up_arlen), .up_arsize(up_arsize),
    .up_arburst(up_arburst), .up_arvalid(up_arvalid), .up_arready(up_arready),
    .up_rid(up_rid), .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rlast(up_rlast),
    .up_rvalid(up_rvalid), .up_rready(up_rready),
    .dn_awid(dn_awid), .dn_awaddr(dn_awaddr), .dn_awlen(dn_awlen), .dn_awsize(dn_awsize),
    .dn_awburst(dn_awburst), .dn_awvalid(dn_awvalid), .dn_awready(dn_awready),
    .dn_wid(dn_wid), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb), .dn_wlast(dn_wlast),
    .dn_wvalid(dn_wvalid), .dn_wready(dn_wready),
    .dn_bid(dn_bid), .dn_bresp(dn_bresp), .dn_bvalid(dn_bvalid), .dn_bready(dn_bready),
    .dn_arid(dn_arid), .dn_araddr(dn_araddr), .dn_arlen(dn_arlen), .dn_arsize(dn_arsize),
    .dn_arburst(dn_arburst), .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
    .dn_rid(dn_rid), .dn_rdata(dn_rdata), .dn_rresp(dn_rresp), .dn_rlast(dn_rlast),
    .dn_rvalid(dn_rvalid), .dn_rready(dn_rready),
    .busy(busy), .timeout(timeout)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed === expected) num_pass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [10:0] ctrlOutputs();
    return {dn_awvalid, dn_wvalid, dn_bready, dn_arvalid, dn_rready,
            up_awready, up_wready, up_bvalid, up_arready, up_rvalid, busy};
  endfunction

  task automatic clearInputs();
    comm_disable = 1'b0;
    up_awid = '0; up_awaddr = '0; up_awlen = '0; up_awsize = 3'd2; up_awburst = 2'b01; up_awvalid = 1'b0;
    up_wid = '0; up_wdata = '0; up_wstrb = '1; up_wlast = 1'b0; up_wvalid = 1'b0; up_bready = 1'b0;
    up_arid = '0; up_araddr = '0; up_arlen = '0; up_arsize = 3'd2; up_arburst = 2'b01; up_arvalid = 1'b0;
    up_rready = 1'b0;
    dn_awready = 1'b0; dn_wready = 1'b0; dn_bid = '0; dn_bresp = '0; dn_bvalid = 1'b0;
    dn_arready = 1'b0; dn_rid = '0; dn_rdata = '0; dn_rresp = '0; dn_rlast = 1'b0; dn_rvalid = 1'b0;
  endtask

  // Reset with every request and ready active: nothing may leak through.
  task automatic doReset();
    @(negedge clk_slave);
    rst_slave = 1'b1;
    up_awvalid = 1'b1; up_wvalid = 1'b1; up_arvalid = 1'b1; up_bready = 1'b1; up_rready = 1'b1;
    dn_awready = 1'b1; dn_wready = 1'b1; dn_arready = 1'b1; dn_bvalid = 1'b1; dn_rvalid = 1'b1;
    repeat (3) @(negedge clk_slave);
    #1;
    checkOutput("reset_outputs", 64'(ctrlOutputs()), 0);
    checkOutput("reset_timeout", 64'(timeout), 0);
    @(negedge clk_slave);
    rst_slave = 1'b0;
    clearInputs();
    model_last_wr = 1'b0;
    @(negedge clk_slave);
  endtask

  task automatic resetMidWrite();
    int  beats = 0;
    bit  aw_done = 1'b0;
    clearInputs();
    up_awid = 4'h9; up_awaddr = 32'h0000_1000; up_awlen = 8'd3;
    dn_awready = 1'b1; dn_wready = 1'b1;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk_slave);
      up_awvalid = !aw_done;
      up_wvalid  = 1'b1;
      up_wdata   = $urandom;
      #1;
      if (up_awvalid && up_awready) aw_done = 1'b1;
      if (dn_wvalid && dn_wready) beats++;
    end
    checkOutput("pre_reset_beats", 64'(beats), 2);
    @(negedge clk_slave);
    rst_slave = 1'b1;
    @(negedge clk_slave);
    rst_slave  = 1'b0;
    up_awvalid = 1'b0;
    #1;
    checkOutput("mid_reset_outputs", 64'(ctrlOutputs()), 0);
    model_last_wr = 1'b0;
    @(negedge clk_slave);
    clearInputs();
    @(negedge clk_slave);
  endtask

  // One scenario: an optional write and/or read presented together, comm_disable held for dis cycles.
  task automatic applyStimulus(input bit do_wr, input bit do_rd, input int dis);
    int            wlen, rlen, cyc, viol, w_up, w_dn, r_up, r_dn, g_wr, g_rd, done_wr, done_rd, busy_bubble;
    bit            aw_up_done, ar_up_done, aw_dn_done, ar_dn_done, b_pend, b_got, pair, first_wr;
    logic [IW-1:0] wid, rid, slv_awid, slv_arid;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata [8];
    logic [DW-1:0] rdata [8];
    logic [1:0]    bresp, rresp;

    wlen = $urandom_range(0, 3);
    rlen = $urandom_range(0, 7);
    wid = IW'($urandom); rid = IW'($urandom);
    waddr = $urandom; raddr = $urandom;
    bresp = 2'($urandom); rresp = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      wdata[i] = $urandom;
      rdata[i] = $urandom;
    end
    viol = 0; w_up = 0; w_dn = 0; r_up = 0; r_dn = 0; g_wr = -1; g_rd = -1;
    done_wr = -10; done_rd = -10; busy_bubble = 2;
    aw_up_done = 0; ar_up_done = 0; aw_dn_done = 0; ar_dn_done = 0; b_pend = 0; b_got = 0;
    slv_awid = '0; slv_arid = '0;
    pair = do_wr && do_rd;
    first_wr = pair ? !model_last_wr : do_wr;
    model_last_wr = pair ? !first_wr : do_wr;

    up_awid = wid; up_wid = wid; up_awaddr = waddr; up_awlen = wlen[7:0];
    up_arid = rid; up_araddr = raddr; up_arlen = rlen[7:0];

    for (cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk_slave);
      comm_disable = (cyc < dis) || (!pair && cyc > dis + 1 && $urandom_range(0, 1) == 1);
      up_awvalid = do_wr && !aw_up_done;
      up_wvalid  = do_wr && (w_up <= wlen);
      up_wdata   = wdata[w_up & 7];
      up_wlast   = (w_up == wlen);
      up_bready  = 1'($urandom_range(0, 1));
      up_arvalid = do_rd && !ar_up_done;
      up_rready  = 1'($urandom_range(0, 1));
      dn_awready = 1'($urandom_range(0, 1));
      dn_wready  = 1'($urandom_range(0, 1));
      dn_arready = 1'($urandom_range(0, 1));
      dn_bvalid  = b_pend; dn_bid = slv_awid; dn_bresp = bresp;
      dn_rvalid  = ar_dn_done && (r_dn <= rlen);
      dn_rdata   = rdata[r_dn & 7];
      dn_rlast   = (r_dn == rlen);
      dn_rid     = slv_arid; dn_rresp = rresp;
      #1;
      if (dn_awvalid && g_wr < 0) g_wr = cyc;
      if (dn_arvalid && g_rd < 0) g_rd = cyc;
      if (pair && cyc == (first_wr ? done_wr : done_rd) + 1) busy_bubble = int'(busy);
      if (dn_awvalid && dn_arvalid) viol++;
      if (busy && cyc <= dis) viol++;
      if (up_wready && !aw_dn_done) viol++;
      if (up_rvalid && !ar_dn_done) viol++;
      if (up_awready && !dn_awvalid) viol++;
      if (up_arready && !dn_arvalid) viol++;
      if ((dn_bready && !up_bready) || (dn_rready && !up_rready)) viol++;
      if (up_bvalid && !b_pend) viol++;

      if (dn_awvalid && dn_awready) begin
        checkOutput("aw_addr", 64'(dn_awaddr), 64'(waddr));
        checkOutput("aw_id_len", 64'({dn_awid, dn_awlen}), 64'({wid, wlen[7:0]}));
        slv_awid = dn_awid;
        aw_dn_done = 1'b1;
      end
      if (up_awvalid && up_awready) aw_up_done = 1'b1;
      if (dn_wvalid && dn_wready) begin
        checkOutput("w_beat", 64'({dn_wlast, dn_wdata}), 64'({w_dn == wlen, wdata[w_dn & 7]}));
        w_dn++;
        if (dn_wlast) b_pend = 1'b1;
      end
      if (up_wvalid && up_wready) w_up++;
      if (dn_bvalid && dn_bready) b_pend = 1'b0;
      if (up_bvalid && up_bready) begin
        checkOutput("b_id_resp", 64'({up_bid, up_bresp}), 64'({wid, bresp}));
        b_got = 1'b1;
        done_wr = cyc;
      end
      if (dn_arvalid && dn_arready) begin
        checkOutput("ar_addr", 64'(dn_araddr), 64'(raddr));
        checkOutput("ar_id_len", 64'({dn_arid, dn_arlen}), 64'({rid, rlen[7:0]}));
        slv_arid = dn_arid;
        ar_dn_done = 1'b1;
      end
      if (up_arvalid && up_arready) ar_up_done = 1'b1;
      if (dn_rvalid && dn_rready) r_dn++;
      if (up_rvalid && up_rready) begin
        checkOutput("r_beat", 64'({up_rlast, up_rid, up_rresp, up_rdata}),
                    64'({r_up == rlen, rid, rresp, rdata[r_up & 7]}));
        r_up++;
        if (up_rlast) done_rd = cyc;
      end
      if ((!do_wr || b_got) && (!do_rd || done_rd >= 0)) break;
    end

    checkOutput("cycle_budget", 64'(cyc < BUDGET), 1);
    if (do_wr) checkOutput("wr_grant_cycle", 64'(g_wr), 64'(first_wr ? dis + 1 : done_rd + 2));
    if (do_rd) checkOutput("rd_grant_cycle", 64'(g_rd), 64'(!first_wr ? dis + 1 : done_wr + 2));
    if (pair) checkOutput("bubble_busy", 64'(busy_bubble), 0);
    checkOutput("beat_counts", {w_dn, r_dn}, {(do_wr ? wlen + 1 : 0), (do_rd ? rlen + 1 : 0)});
    checkOutput("protocol", 64'(viol), 0);
    checkOutput("timeout_flag", 64'(timeout), 0);

    @(negedge clk_slave);
    up_awvalid = 1'b0; up_wvalid = 1'b0; up_arvalid = 1'b0;
    dn_bvalid = 1'b0; dn_rvalid = 1'b0;
    #1;
    checkOutput("idle_after", 64'(ctrlOutputs()), 0);
    if (cyc >= BUDGET) doReset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int kind;
    clearInputs();
    rst_slave = 1'b1;
    doReset();
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 0);
    resetMidWrite();
    applyStimulus(1'b1, 1'b1, 1);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, kind != 0, ($urandom_range(0, 4) == 0) ? 10 : $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
